cmp_share_arbiter: RTL and testbench

- Shares one combinational 4-bit magnitude comparator (eq/lt/gt) between NUM_REQ requesters in the calculator datapath.
- Uses round-robin arbitration and a valid/ready handshake on each side.
- Registers the operands, sequences one compare, and returns a tagged result.
- Sits between the calculator's operation decoders (requesters) and the comparator instance.

---
 rtl/cmp_arb_pkg.sv | 15 +
 rtl/cmp_share_arbiter_if.sv | 30 +++
 rtl/cmp_share_arbiter_rr_pick.sv | 33 +++
 rtl/comparator4bit.sv | 14 +
 rtl/cmp_share_arbiter.sv | 97 +++++++++
 tb/tb_cmp_share_arbiter.sv | 224 ++++++++++++++++++++++
 6 files changed

// File: rtl/cmp_arb_pkg.sv
// Shared encodings for the comparator-sharing arbiter: FSM states and the
// bit positions of the eq/lt/gt result vector.
package cmp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int RES_EQ = 0;
  localparam int RES_LT = 1;
  localparam int RES_GT = 2;

endpackage

// File: rtl/cmp_share_arbiter_if.sv
// Requester-side and response-side handshake bundle of the comparator arbiter.
interface cmp_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) ();

  logic [NUM_REQ-1:0]   req_valid;
  logic [4*NUM_REQ-1:0] req_a;
  logic [4*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [ID_W-1:0]      resp_id;
  logic                 resp_eq;
  logic                 resp_lt;
  logic                 resp_gt;

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_eq, resp_lt, resp_gt
  );

  // Requester/consumer side.
  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_eq, resp_lt, resp_gt
  );

endinterface

// File: rtl/cmp_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward with wrap-around.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any_req
);

  logic [ID_W-1:0] idx;

  // NOTE: every variable gets a default before the search so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any_req    = 1'b0;
    idx        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        gnt_idx    = idx;
        gnt_onehot = NUM_REQ'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/comparator4bit.sv
// The calculator's existing unsigned 4-bit magnitude comparator.
module Comparator4Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       eq,
  output logic       lt,
  output logic       gt
);

  assign eq = (a == b);
  assign lt = (a <  b);
  assign gt = (a >  b);

endmodule

// File: rtl/cmp_share_arbiter.sv
// Shares one 4-bit comparator among NUM_REQ requesters: round-robin grant,
// one registered compare, tagged result held until the consumer accepts it.
module cmp_share_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  cmp_share_arbiter_if.slave  bus,
  output logic                busy,
  output logic [CNT_W-1:0]    op_count
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr, gnt_idx, id_r;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic               any_req;
  logic [3:0]         a_r, b_r;
  logic [2:0]         cmp_res;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req        (bus.req_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any_req    (any_req)
  );

  Comparator4Bit u_cmp (
    .a  (a_r),
    .b  (b_r),
    .eq (cmp_res[RES_EQ]),
    .lt (cmp_res[RES_LT]),
    .gt (cmp_res[RES_GT])
  );

  // The acceptance pulse is gated by rst_n so it stays low while held in reset.
  assign bus.req_ready = (state_q == ST_IDLE && rst_n) ? gnt_onehot : '0;
  assign busy          = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (any_req)        state_d = ST_CMP;
      ST_CMP:                      state_d = ST_RESP;
      ST_RESP: if (bus.resp_ready) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      id_r           <= '0;
      a_r            <= '0;
      b_r            <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_id    <= '0;
      bus.resp_eq    <= 1'b0;
      bus.resp_lt    <= 1'b0;
      bus.resp_gt    <= 1'b0;
      op_count       <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (any_req) begin
          a_r    <= bus.req_a[{gnt_idx, 2'b00} +: 4];
          b_r    <= bus.req_b[{gnt_idx, 2'b00} +: 4];
          id_r   <= gnt_idx;
          rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
        ST_CMP: begin
          bus.resp_eq    <= cmp_res[RES_EQ];
          bus.resp_lt    <= cmp_res[RES_LT];
          bus.resp_gt    <= cmp_res[RES_GT];
          bus.resp_id    <= id_r;
          bus.resp_valid <= 1'b1;
        end
        ST_RESP: if (bus.resp_ready) begin
          bus.resp_valid <= 1'b0;
          op_count       <= op_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed plus randomized bench for cmp_share_arbiter against a queue-free
// behavioural model: rotating-priority grant and plain integer comparison.
module tb_cmp_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 8;

  logic             clk;
  logic             rst_n;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  cmp_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  cmp_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Stimulus arrays and model state
  logic [NUM_REQ-1:0] tv;
  logic [3:0]         ta [NUM_REQ];
  logic [3:0]         tb_ [NUM_REQ];
  int                 m_ptr;
  int                 m_cnt;
  int                 last_g;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.req_valid = tv;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a[4*i +: 4] = ta[i];
      bus.req_b[4*i +: 4] = tb_[i];
    end
  endtask

  task automatic randomize_inputs();
    tv = NUM_REQ'($urandom);
    for (int i = 0; i < NUM_REQ; i++) begin
      ta[i]  = 4'($urandom);
      tb_[i] = 4'($urandom);
    end
    apply();
    bus.resp_ready = 1'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},  32'(bus.req_ready),  0);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 0);
    check({tag, "_resp_id"},    32'(bus.resp_id),    0);
    check({tag, "_resp_eq"},    32'(bus.resp_eq),    0);
    check({tag, "_resp_lt"},    32'(bus.resp_lt),    0);
    check({tag, "_resp_gt"},    32'(bus.resp_gt),    0);
    check({tag, "_busy"},       32'(busy),           0);
    check({tag, "_op_count"},   32'(op_count),       0);
  endtask

  // Entered at a negedge in IDLE with the request inputs already applied.
  // Walks one operation through grant, compare, held response and handshake.
  task automatic do_op(input string tag, input int hold, output int g);
    int ea, eb;
    g = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (tv[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
    ea = int'(ta[g]);
    eb = int'(tb_[g]);
    #1;
    check({tag, "_grant"}, 32'(bus.req_ready), 32'(1 << g));
    m_ptr = (g + 1) % NUM_REQ;

    @(negedge clk);
    bus.resp_ready = 1'($urandom);
    check({tag, "_cmp_busy"},  32'(busy),           1);
    check({tag, "_cmp_valid"}, 32'(bus.resp_valid), 0);
    check({tag, "_cmp_ready"}, 32'(bus.req_ready),  0);

    @(negedge clk);
    bus.resp_ready = (hold == 0);
    check({tag, "_valid"}, 32'(bus.resp_valid), 1);
    check({tag, "_id"},    32'(bus.resp_id),    32'(g));
    check({tag, "_eq"},    32'(bus.resp_eq),    32'(ea == eb));
    check({tag, "_lt"},    32'(bus.resp_lt),    32'(ea < eb));
    check({tag, "_gt"},    32'(bus.resp_gt),    32'(ea > eb));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(bus.resp_valid), 1);
      check({tag, "_hold_eq"},    32'(bus.resp_eq),    32'(ea == eb));
      check({tag, "_hold_gt"},    32'(bus.resp_gt),    32'(ea > eb));
      check({tag, "_hold_ready"}, 32'(bus.req_ready),  0);
      check({tag, "_hold_cnt"},   32'(op_count),       32'(m_cnt % (1 << CNT_W)));
      if (h == hold - 1) bus.resp_ready = 1'b1;
    end

    @(negedge clk);
    m_cnt++;
    check({tag, "_done_valid"}, 32'(bus.resp_valid), 0);
    check({tag, "_done_busy"},  32'(busy),           0);
    check({tag, "_done_cnt"},   32'(op_count),       32'(m_cnt % (1 << CNT_W)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int bnd_a [4] = '{0, 15, 0, 15};
    int bnd_b [4] = '{0, 0, 15, 15};

    rst_n = 1'b0;
    m_ptr = 0;
    m_cnt = 0;
    randomize_inputs();
    repeat (3) begin
      @(negedge clk);
      randomize_inputs();
      #1;
      check_all_zero("rst_hold");
    end
    tv = '0;
    apply();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request from requester 2: 9 > 3
    tv = 4'b0100; ta[2] = 4'd9; tb_[2] = 4'd3;
    apply();
    do_op("single", 0, last_g);
    check("single_id", 32'(last_g), 2);
    check("single_cnt", 32'(op_count), 1);
    tv = '0;
    apply();

    // Reset while the compare is in flight: the request is dropped
    tv = 4'b0001; ta[0] = 4'd3; tb_[0] = 4'd7;
    apply();
    #1;
    check("mid_rst_grant", 32'(bus.req_ready), 1);
    @(negedge clk);
    check("mid_rst_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    tv = '0;
    apply();
    #1;
    check("mid_rst_valid", 32'(bus.resp_valid), 0);
    check("mid_rst_busy",  32'(busy),           0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    m_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_no_resp", 32'(bus.resp_valid), 0);
      check("mid_rst_cnt",     32'(op_count),       0);
    end

    // Round-robin with every requester valid: a_i = i, b_i = 2
    for (int i = 0; i < NUM_REQ; i++) begin
      ta[i]  = 4'(i);
      tb_[i] = 4'd2;
    end
    tv = '1;
    apply();
    for (int n = 0; n < 5; n++) begin
      do_op("rr", 0, last_g);
      check("rr_order", 32'(last_g), 32'(exp_order[n]));
    end

    // Backpressure: 5 cycles with resp_ready low, then an immediate re-grant
    for (int i = 0; i < NUM_REQ; i++) begin
      ta[i]  = 4'd5;
      tb_[i] = 4'd5;
    end
    apply();
    do_op("bp", 5, last_g);
    do_op("bp_next", 0, last_g);

    // Operand corners
    for (int n = 0; n < 4; n++) begin
      tv = 4'b0001;
      ta[0]  = 4'(bnd_a[n]);
      tb_[0] = 4'(bnd_b[n]);
      apply();
      do_op("bnd", 0, last_g);
    end

    // Random traffic until 256 operations complete since the last reset
    while (m_cnt < 256) begin
      tv = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        ta[i]  = 4'($urandom);
        tb_[i] = 4'($urandom);
      end
      apply();
      do_op("rand", $urandom_range(0, 3), last_g);
    end
    check("wrap_cnt", 32'(op_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
